// File: rtl/axi4lite_sub_bridge.sv
// AXI4-Lite subordinate that re-issues each transaction as a single wr/rd strobe on the simple bus.
// Read and write paths are independent FSMs, each with a done-timeout that answers SLVERR.
module axi4lite_sub_bridge #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT            = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     wrAddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     wrData,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   wrStrb,
    output logic                              wr,
    input  logic                              wrDone,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     rdAddr,
    output logic                              rd,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     rdData,
    input  logic                              rdDone
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rstate_t;

    wstate_t                           r_wstate;
    rstate_t                           r_rstate;
    logic                              r_aw_got, r_w_got;
    logic                              r_awready, r_wready, r_arready;
    logic                              r_bvalid, r_rvalid;
    logic [1:0]                        r_bresp, r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_rdata;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     r_wr_addr, r_rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   r_wr_strb;
    logic                              r_wr, r_rd;
    logic [7:0]                        r_wcnt, r_rcnt;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have;

    // READY is only ever high in IDLE, so the handshakes need no state qualification
    assign w_aw_hs   = r_awready & S_AXI_AWVALID;
    assign w_w_hs    = r_wready  & S_AXI_WVALID;
    assign w_ar_hs   = r_arready & S_AXI_ARVALID;
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got  | w_w_hs;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate  <= W_IDLE;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_strb <= '0;
            r_wr      <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wr_addr <= S_AXI_AWADDR;
                        r_aw_got  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wr_data <= S_AXI_WDATA;
                        r_wr_strb <= S_AXI_WSTRB;
                        r_w_got   <= 1'b1;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_wstate  <= W_REQ;
                        r_wr      <= 1'b1;
                        r_wcnt    <= '0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= ~w_aw_have;
                        r_wready  <= ~w_w_have;
                    end
                end
                W_REQ, W_WAIT: begin
                    if (wrDone) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_OKAY;
                    end else if (r_wcnt == TO_LAST) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= RESP_SLVERR;
                    end else begin
                        r_wstate <= W_WAIT;
                        r_wcnt   <= r_wcnt + 8'd1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_rd_addr <= '0;
            r_rd      <= 1'b0;
            r_rcnt    <= '0;
        end else begin
            r_rd <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rd_addr <= S_AXI_ARADDR;
                        r_rstate  <= R_REQ;
                        r_rd      <= 1'b1;
                        r_rcnt    <= '0;
                        r_arready <= 1'b0;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_REQ, R_WAIT: begin
                    if (rdDone) begin
                        r_rstate <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_OKAY;
                        r_rdata  <= rdData;
                    end else if (r_rcnt == TO_LAST) begin
                        r_rstate <= R_RESP;
                        r_rvalid <= 1'b1;
                        r_rresp  <= RESP_SLVERR;
                        r_rdata  <= '0;
                    end else begin
                        r_rstate <= R_WAIT;
                        r_rcnt   <= r_rcnt + 8'd1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign wrAddr        = r_wr_addr;
    assign wrData        = r_wr_data;
    assign wrStrb        = r_wr_strb;
    assign wr            = r_wr;
    assign rdAddr        = r_rd_addr;
    assign rd            = r_rd;

endmodule
